// File: rtl/bp_fe_ltb_update_queue.sv
// Update queue between branch resolution and the loop termination buffer.
// Resolution cannot stall, so this FIFO absorbs LTB write-port backpressure.
// On overflow it keeps mispredict updates ahead of non-mispredict updates.
// Every lost update is counted.
module bp_fe_ltb_update_queue #(
    parameter int vaddr_width_p    = 39,
    parameter int els_p            = 8,
    parameter int drop_cnt_width_p = 8,
    localparam int ptr_w_lp        = $clog2(els_p),
    localparam int cnt_w_lp        = $clog2(els_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        init_done_i,
    input  logic                        flush_i,
    input  logic                        upd_v_i,
    input  logic                        upd_mispredict_i,
    input  logic                        upd_taken_i,
    input  logic [vaddr_width_p-1:0]    upd_src_addr_i,
    output logic                        w_v_o,
    output logic                        w_mispredict_o,
    output logic                        w_taken_o,
    output logic [vaddr_width_p-1:0]    w_src_addr_o,
    input  logic                        w_yumi_i,
    output logic [cnt_w_lp-1:0]         count_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

    logic [ptr_w_lp-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [ptr_w_lp-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [cnt_w_lp-1:0]         count_reg, count_next;
    logic [drop_cnt_width_p-1:0] drop_cnt_reg, drop_cnt_next;

    logic                        mispredict_mem_reg [els_p];
    logic                        taken_mem_reg      [els_p];
    logic [vaddr_width_p-1:0]    src_addr_mem_reg   [els_p];

    logic                        empty, full;
    logic                        deq, enq, drop, overwrite, wr_any;
    logic [ptr_w_lp-1:0]         newest_ptr, wr_sel_ptr;

    // Head entry is presented combinationally; valid is gated by LTB init.
    always_comb begin
        empty          = (count_reg == '0);
        full           = (count_reg == cnt_w_lp'(els_p));
        w_v_o          = ~empty & init_done_i;
        w_mispredict_o = mispredict_mem_reg[rd_ptr_reg];
        w_taken_o      = taken_mem_reg[rd_ptr_reg];
        w_src_addr_o   = src_addr_mem_reg[rd_ptr_reg];
        count_o        = count_reg;
        drop_cnt_o     = drop_cnt_reg;
    end

    // Decide pop/push/overflow actions; flush overrides everything else.
    always_comb begin
        newest_ptr = wr_ptr_reg - 1'b1;
        // A yumi without a valid head is ignored, so it never frees a slot.
        deq        = w_yumi_i & w_v_o & ~flush_i;
        enq        = upd_v_i & ~flush_i & (~full | deq);
        drop       = upd_v_i & ~flush_i & full & ~deq;
        // Full and stalled: a mispredict may evict a non-mispredict newest entry.
        overwrite  = drop & upd_mispredict_i & ~mispredict_mem_reg[newest_ptr];
        wr_any     = enq | overwrite;
        wr_sel_ptr = enq ? wr_ptr_reg : newest_ptr;

        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        drop_cnt_next = drop_cnt_reg;

        if (flush_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (deq) rd_ptr_next = rd_ptr_reg + 1'b1;
            if (enq) wr_ptr_next = wr_ptr_reg + 1'b1;
            case ({enq, deq})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end

        if (drop && !(&drop_cnt_reg)) drop_cnt_next = drop_cnt_reg + 1'b1;
    end

    // Pointer, occupancy and drop-counter state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Per-entry storage; written on a normal push or a mispredict overwrite.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                mispredict_mem_reg[gi] <= 1'b0;
                taken_mem_reg[gi]      <= 1'b0;
                src_addr_mem_reg[gi]   <= '0;
            end else if (wr_any && (wr_sel_ptr == ptr_w_lp'(gi))) begin
                mispredict_mem_reg[gi] <= upd_mispredict_i;
                taken_mem_reg[gi]      <= upd_taken_i;
                src_addr_mem_reg[gi]   <= upd_src_addr_i;
            end
        end
    end

`ifndef SYNTHESIS
    // The LTB must not acknowledge a head that is not being offered.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w_yumi_i && !w_v_o))
                else $error("w_yumi_i asserted while w_v_o is low");
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_ltb_update_queue.sv
// Randomized and directed checks of the LTB update queue against a
// queue-based reference model; a second instance checks counter saturation.
module tb_bp_fe_ltb_update_queue;

    localparam int VW  = 39;
    localparam int ELS = 8;
    localparam int CW  = $clog2(ELS + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, init_done, flush, upd_v, upd_m, upd_t, yumi;
    logic [VW-1:0] upd_a;

    logic          a_v, a_m, a_t;
    logic [VW-1:0] a_addr;
    logic [CW-1:0] a_count;
    logic [7:0]    a_drop;

    logic          b_v, b_m, b_t;
    logic [VW-1:0] b_addr;
    logic [CW-1:0] b_count;
    logic [1:0]    b_drop;

    bp_fe_ltb_update_queue #(.vaddr_width_p(VW), .els_p(ELS), .drop_cnt_width_p(8)) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .init_done_i(init_done), .flush_i(flush),
        .upd_v_i(upd_v), .upd_mispredict_i(upd_m), .upd_taken_i(upd_t), .upd_src_addr_i(upd_a),
        .w_v_o(a_v), .w_mispredict_o(a_m), .w_taken_o(a_t), .w_src_addr_o(a_addr),
        .w_yumi_i(yumi), .count_o(a_count), .drop_cnt_o(a_drop)
    );

    bp_fe_ltb_update_queue #(.vaddr_width_p(VW), .els_p(ELS), .drop_cnt_width_p(2)) u_dut_sat (
        .clk_i(clk), .reset_n_i(reset_n), .init_done_i(init_done), .flush_i(flush),
        .upd_v_i(upd_v), .upd_mispredict_i(upd_m), .upd_taken_i(upd_t), .upd_src_addr_i(upd_a),
        .w_v_o(b_v), .w_mispredict_o(b_m), .w_taken_o(b_t), .w_src_addr_o(b_addr),
        .w_yumi_i(yumi), .count_o(b_count), .drop_cnt_o(b_drop)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            m;
        bit            t;
        logic [VW-1:0] a;
    } ent_t;

    ent_t q[$];
    int   drops = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare both instances against the model's view of the queue.
    task automatic check_outputs();
        logic exp_v;
        exp_v = (q.size() > 0) && init_done;
        check_val("w_v", 64'(a_v), 64'(exp_v));
        check_val("count", 64'(a_count), 64'(q.size()));
        check_val("drop_cnt", 64'(a_drop), 64'((drops > 255) ? 255 : drops));
        check_val("sat_w_v", 64'(b_v), 64'(exp_v));
        check_val("sat_count", 64'(b_count), 64'(q.size()));
        check_val("sat_drop_cnt", 64'(b_drop), 64'((drops > 3) ? 3 : drops));
        if (q.size() > 0) begin
            check_val("head_addr", 64'(a_addr), 64'(q[0].a));
            check_val("head_misp", 64'(a_m), 64'(q[0].m));
            check_val("head_taken", 64'(a_t), 64'(q[0].t));
            check_val("sat_head_addr", 64'(b_addr), 64'(q[0].a));
            check_val("sat_head_misp", 64'(b_m), 64'(q[0].m));
            check_val("sat_head_taken", 64'(b_t), 64'(q[0].t));
        end
    endtask

    // One clock of stimulus: drive at negedge, check, clock, advance model.
    task automatic cycle(input bit in, input bit fl, input bit v, input bit m, input bit t,
                         input logic [VW-1:0] a, input bit y);
        ent_t e;
        bit   yy;
        @(negedge clk);
        init_done = in;
        flush     = fl;
        upd_v     = v;
        upd_m     = m;
        upd_t     = t;
        upd_a     = a;
        yy        = y && (q.size() > 0) && in;
        yumi      = yy;
        #1;
        check_outputs();
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (yy) void'(q.pop_front());
            if (v) begin
                e.m = m;
                e.t = t;
                e.a = a;
                if (q.size() < ELS) begin
                    q.push_back(e);
                end else begin
                    drops++;
                    if (m && !q[q.size()-1].m) q[q.size()-1] = e;
                end
            end
        end
        #1;
        flush = 1'b0;
        upd_v = 1'b0;
        yumi  = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        init_done = 1'b0;
        flush     = 1'b0;
        upd_v     = 1'b0;
        upd_m     = 1'b0;
        upd_t     = 1'b0;
        upd_a     = '0;
        yumi      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Ordering with yumi whenever the head is offered
        cycle(1, 0, 1, 0, 1, 39'h100, 1);
        cycle(1, 0, 1, 0, 0, 39'h104, 1);
        cycle(1, 0, 1, 1, 1, 39'h108, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, '0, 1);
        settle();
        check_val("order_empty", 64'(a_count), 64'd0);

        // Fill to eight and drop a ninth non-mispredict update
        for (int i = 0; i < 9; i++) cycle(1, 0, 1, 0, i[0], 39'h100 + 39'(4 * i), 0);
        settle();
        check_val("fill_count", 64'(a_count), 64'd8);
        check_val("fill_drop", 64'(a_drop), 64'd1);
        check_val("fill_head", 64'(a_addr), 64'h100);

        // Mispredict replaces the non-mispredict newest entry; second one is lost
        cycle(1, 0, 1, 1, 1, 39'h200, 0);
        settle();
        check_val("misp_count", 64'(a_count), 64'd8);
        check_val("misp_drop", 64'(a_drop), 64'd2);
        cycle(1, 0, 1, 1, 0, 39'h300, 0);
        settle();
        check_val("misp2_drop", 64'(a_drop), 64'd3);

        // Full with simultaneous push and pop, then drain across the wrap
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0, 39'h400 + 39'(4 * i), 1);
        settle();
        check_val("fullpp_count", 64'(a_count), 64'd8);
        check_val("fullpp_drop", 64'(a_drop), 64'd3);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0, '0, 1);
        settle();
        check_val("drain_count", 64'(a_count), 64'd0);

        // Init gating, then flush with a concurrent update and yumi
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 39'h500 + 39'(4 * i), 1);
        settle();
        check_val("init_low_v", 64'(a_v), 64'd0);
        cycle(1, 0, 0, 0, 0, '0, 0);
        settle();
        check_val("init_high_v", 64'(a_v), 64'd1);
        check_val("init_head", 64'(a_addr), 64'h500);
        cycle(1, 1, 1, 1, 0, 39'h600, 1);
        settle();
        check_val("flush_count", 64'(a_count), 64'd0);
        check_val("flush_v", 64'(a_v), 64'd0);
        check_val("flush_drop", 64'(a_drop), 64'd3);

        // Asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 39'h700 + 39'(4 * i), 0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("areset_count", 64'(a_count), 64'd0);
        check_val("areset_v", 64'(a_v), 64'd0);
        check_val("areset_drop", 64'(a_drop), 64'd0);
        q.delete();
        drops = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 3),
                  $urandom_range(0, 1),
                  {$urandom, $urandom} & {VW{1'b1}},
                  ($urandom_range(0, 9) < 4));
        end
        settle();
        if (drops >= 5) check_val("sat_final", 64'(b_drop), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_fe_ltb_update_queue.md
Name: bp_fe_ltb_update_queue

Overview:
- Buffers resolved-branch training updates from branch resolution and replays them in order into the loop termination buffer write port.
- The LTB write port has a yumi handshake and rejects writes that collide with a same-cycle read. Branch resolution cannot stall, so this FIFO absorbs the mismatch.
- On overflow, the queue protects mispredict updates at the expense of non-mispredict updates, and counts every lost update.

Parameters:
- vaddr_width_p, 39, virtual address width of the branch source PC.
- els_p, 8, queue depth in entries; power of two, at least 2.
- drop_cnt_width_p, 8, width of the saturating dropped-update counter.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous, active-low
- init_done_i  in  1  LTB initialization complete; gates dequeue
- flush_i  in  1  discard all queued updates
- upd_v_i  in  1  resolved-branch update valid; no backpressure
- upd_mispredict_i  in  1  branch was mispredicted
- upd_taken_i  in  1  branch resolved taken
- upd_src_addr_i  in  vaddr_width_p  branch PC
- w_v_o  out  1  head update valid toward the LTB
- w_mispredict_o  out  1  head entry mispredict bit
- w_taken_o  out  1  head entry taken bit
- w_src_addr_o  out  vaddr_width_p  head entry PC
- w_yumi_i  in  1  LTB consumed the head this cycle
- count_o  out  $clog2(els_p+1)  current occupancy
- drop_cnt_o  out  drop_cnt_width_p  saturating count of lost updates

Behaviour:
- Clock and reset: one clock, clk_i. reset_n_i is asynchronous, active-low.
- Reset values: empty queue; rd/wr pointers 0; count_o=0; drop_cnt_o=0; w_v_o=0. Data outputs are don't-care while w_v_o=0; they are registered storage, zero after reset.
- Storage: els_p entries of {mispredict, taken, src_addr}. Circular buffer with wrap-around pointers of $clog2(els_p) bits.
- Full/empty are tracked by the occupancy counter, not by pointer compare.
- Output:
  - w_v_o = ~empty & init_done_i.
  - Data outputs are driven combinationally from the head entry.
  - A newly enqueued entry first appears on w_v_o the cycle after enqueue; there is no same-cycle bypass.
- Dequeue: on w_yumi_i, the head is popped and rd_ptr advances with wrap.
  - w_yumi_i while w_v_o=0 is illegal; assert in simulation and ignore in logic.
- Enqueue when not full, or when full and w_yumi_i is set the same cycle: upd_v_i writes at wr_ptr, which advances. No drop.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Enqueue when full and w_yumi_i=0:
  - If upd_mispredict_i=1 and the newest entry (wr_ptr-1, with wrap) has mispredict=0: overwrite the newest entry with the incoming update. Pointers are unchanged; drop_cnt increments.
  - Otherwise the incoming update is discarded and drop_cnt increments.
- drop_cnt saturates at all-ones, and is cleared only by reset.
- Flush: flush_i empties the queue in one cycle (pointers and count to 0), taking priority over enqueue and dequeue.
  - A same-cycle upd_v_i is discarded and not counted.
  - w_yumi_i in a flush cycle is ignored.
  - drop_cnt is unaffected.
- init_done_i=0: enqueue proceeds normally and w_v_o is held 0. Entries are retained until init completes.
- Reset asserted mid-operation clears all state immediately (asynchronously). After deassertion the queue resumes from the empty state.

Test Plan:
- Ordering: reset, init_done_i=1, enqueue 3 updates at PCs 0x100, 0x104, 0x108, yumi every cycle. Required: w_v_o rises the cycle after the first enqueue; PCs emerge in order; count_o returns to 0.
- Fill and drop: els_p=8, yumi=0, 9 non-mispredict updates. Required: count_o=8, drop_cnt_o=1, head PC is the first update.
- Mispredict protection: queue full, newest entry non-mispredict at PC 0x11C, enqueue mispredict at 0x200. Required: newest entry now 0x200/mispredict=1, count_o=8, drop_cnt_o incremented. A second mispredict at 0x300 is discarded; drop_cnt_o incremented again.
- Full with simultaneous yumi and enqueue: count_o stays 8, drop_cnt_o unchanged, the new entry lands last; wrap is verified by dequeuing 16 entries in order.
- Flush and init gating: init_done_i=0 with 4 entries, so w_v_o=0. Raise init_done_i: w_v_o=1 and head is the first entry. Assert flush_i with upd_v_i: count_o=0 next cycle, w_v_o=0, drop_cnt_o unchanged.
- Async reset and saturation: reset_n_i low mid-stream clears count_o and w_v_o with no clock edge. With drop_cnt_width_p=2, 5 drops give drop_cnt_o=3.
